// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave front end: buffers AW/W/AR in single-entry slots and serialises them
// into one-at-a-time native bus accesses, returning status/read data on B/R.
module rggen_axi4lite_bridge #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [STROBE_WIDTH-1:0]  i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic [1:0]               o_rresp,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]  o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  localparam int LSB = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);

  function automatic logic [ADDRESS_WIDTH-1:0] align(input logic [ADDRESS_WIDTH-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t                   state;
  logic                     aw_full, w_full, ar_full;
  logic                     write_issued, read_issued;
  logic                     last_read;
  logic [ADDRESS_WIDTH-1:0] aw_addr, ar_addr;
  logic [BUS_WIDTH-1:0]     w_data;
  logic [STROBE_WIDTH-1:0]  w_strb;

  logic                     aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                     wr_pend, rd_pend;
  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;
  logic [BUS_WIDTH-1:0]     wr_data;
  logic [STROBE_WIDTH-1:0]  wr_strb;

  assign o_awready = !aw_full;
  assign o_wready  = !w_full;
  assign o_arready = !ar_full;

  assign aw_hs = i_awvalid & o_awready;
  assign w_hs  = i_wvalid  & o_wready;
  assign ar_hs = i_arvalid & o_arready;
  assign b_hs  = o_bvalid  & i_bready;
  assign r_hs  = o_rvalid  & i_rready;

  // A slot being filled this cycle counts as pending so the registered request
  // appears in the following cycle; the slot contents bypass from the AXI inputs.
  assign wr_pend = (aw_full | aw_hs) & (w_full | w_hs) & !write_issued;
  assign rd_pend = (ar_full | ar_hs) & !read_issued;
  assign wr_addr = aw_full ? aw_addr : i_awaddr;
  assign wr_data = w_full  ? w_data  : i_wdata;
  assign wr_strb = w_full  ? w_strb  : i_wstrb;
  assign rd_addr = ar_full ? ar_addr : i_araddr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      aw_full          <= 1'b0;
      w_full           <= 1'b0;
      ar_full          <= 1'b0;
      write_issued     <= 1'b0;
      read_issued      <= 1'b0;
      last_read        <= 1'b0;
      aw_addr          <= '0;
      ar_addr          <= '0;
      w_data           <= '0;
      w_strb           <= '0;
      o_bvalid         <= 1'b0;
      o_bresp          <= 2'b00;
      o_rvalid         <= 1'b0;
      o_rresp          <= 2'b00;
      o_rdata          <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_access     <= 2'b00;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= i_awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= i_wdata;
        w_strb <= i_wstrb;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= i_araddr;
      end
      if (b_hs) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        write_issued <= 1'b0;
        o_bvalid     <= 1'b0;
      end
      if (r_hs) begin
        ar_full     <= 1'b0;
        read_issued <= 1'b0;
        o_rvalid    <= 1'b0;
      end

      case (state)
        IDLE: begin
          // On a tie, serve whichever kind was not served last.
          if (wr_pend && (!rd_pend || last_read)) begin
            state            <= WRITE;
            last_read        <= 1'b0;
            o_bus_valid      <= 1'b1;
            o_bus_access     <= 2'b01;
            o_bus_address    <= align(wr_addr);
            o_bus_write_data <= wr_data;
            o_bus_strobe     <= wr_strb;
          end else if (rd_pend) begin
            state            <= READ;
            last_read        <= 1'b1;
            o_bus_valid      <= 1'b1;
            o_bus_access     <= 2'b10;
            o_bus_address    <= align(rd_addr);
            o_bus_write_data <= '0;
            o_bus_strobe     <= '0;
          end
        end
        WRITE: begin
          if (i_bus_ready) begin
            state        <= IDLE;
            o_bus_valid  <= 1'b0;
            write_issued <= 1'b1;
            o_bvalid     <= 1'b1;
            o_bresp      <= i_bus_status;
          end
        end
        READ: begin
          if (i_bus_ready) begin
            state       <= IDLE;
            o_bus_valid <= 1'b0;
            read_issued <= 1'b1;
            o_rvalid    <= 1'b1;
            o_rresp     <= i_bus_status;
            o_rdata     <= i_bus_read_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Self-checking bench for rggen_axi4lite_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_rggen_axi4lite_bridge;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [BW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          bus_valid, bus_ready;
  logic [1:0]    bus_access, bus_status;
  logic [AW-1:0] bus_address;
  logic [BW-1:0] bus_write_data, bus_read_data;
  logic [SW-1:0] bus_strobe;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_bus_valid(bus_valid), .o_bus_access(bus_access), .o_bus_address(bus_address),
    .o_bus_write_data(bus_write_data), .o_bus_strobe(bus_strobe),
    .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_read_data)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; rready = 0;
    bus_ready = 0; bus_status = 2'b00; bus_read_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL reset_ready got %b exp 111", {awready, wready, arready}); end
    tests++; if ({bvalid, rvalid, bus_valid} !== 3'b000) begin fails++; $display("FAIL reset_valid got %b exp 000", {bvalid, rvalid, bus_valid}); end
    tests++; if (bus_access !== 2'b00 || bus_address !== '0 || bus_strobe !== '0 || bus_write_data !== '0) begin fails++; $display("FAIL reset_bus got acc=%b addr=%h exp 0", bus_access, bus_address); end
    tests++; if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin fails++; $display("FAIL reset_resp got b=%b r=%b d=%h exp 0", bresp, rresp, rdata); end
  endtask

  task automatic test_write_basic();
    awvalid = 1; awaddr = 8'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    cyc();
    awvalid = 0; wvalid = 0;
    tests++; if (bus_valid !== 1'b1 || bus_access !== 2'b01) begin fails++; $display("FAIL wr_issue got v=%b acc=%b exp 1/01", bus_valid, bus_access); end
    tests++; if (bus_address !== 8'h10 || bus_write_data !== 32'hDEADBEEF || bus_strobe !== 4'hF) begin fails++; $display("FAIL wr_payload got %h/%h/%h exp 10/deadbeef/f", bus_address, bus_write_data, bus_strobe); end
    tests++; if (awready !== 1'b0 || wready !== 1'b0) begin fails++; $display("FAIL wr_ready_low got %b%b exp 00", awready, wready); end
    bus_ready = 1; bus_status = 2'b00;
    cyc();
    bus_ready = 0;
    tests++; if (bvalid !== 1'b1 || bresp !== 2'b00 || bus_valid !== 1'b0) begin fails++; $display("FAIL wr_bvalid got b=%b resp=%b bv=%b exp 1/00/0", bvalid, bresp, bus_valid); end
    cyc();
    tests++; if (awready !== 1'b0 || bvalid !== 1'b1) begin fails++; $display("FAIL wr_hold got awr=%b b=%b exp 0/1", awready, bvalid); end
    bready = 1;
    cyc();
    bready = 0;
    tests++; if ({awready, wready, bvalid} !== 3'b110) begin fails++; $display("FAIL wr_bdone got %b exp 110", {awready, wready, bvalid}); end
  endtask

  task automatic test_w_before_aw();
    logic [BW-1:0] d;
    int n;
    d = $urandom;
    wvalid = 1; wdata = d; wstrb = 4'b0101;
    cyc();
    wvalid = 0;
    tests++; if (wready !== 1'b0 || bus_valid !== 1'b0) begin fails++; $display("FAIL wfirst_wait got wr=%b bv=%b exp 0/0", wready, bus_valid); end
    cyc();
    tests++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL wfirst_noissue got %b exp 0", bus_valid); end
    awvalid = 1; awaddr = 8'h13;
    cyc();
    awvalid = 0;
    tests++; if (bus_valid !== 1'b1 || bus_address !== 8'h10 || bus_strobe !== 4'b0101 || bus_write_data !== d) begin fails++; $display("FAIL wfirst_payload got v=%b a=%h s=%b d=%h exp 1/10/0101/%h", bus_valid, bus_address, bus_strobe, bus_write_data, d); end
    bus_ready = 1; bus_status = 2'b11;
    cyc();
    bus_ready = 0;
    n = 0;
    repeat (5) begin
      if (bus_valid) n++;
      cyc();
    end
    tests++; if (n !== 0 || bvalid !== 1'b1 || bresp !== 2'b11) begin fails++; $display("FAIL wfirst_single got extra=%0d b=%b resp=%b exp 0/1/11", n, bvalid, bresp); end
    bready = 1;
    cyc();
    bready = 0;
  endtask

  task automatic test_read_status();
    arvalid = 1; araddr = 8'h20;
    cyc();
    arvalid = 0;
    tests++; if (bus_valid !== 1'b1 || bus_access !== 2'b10 || bus_address !== 8'h20 || bus_strobe !== 4'h0) begin fails++; $display("FAIL rd_issue got v=%b acc=%b a=%h s=%h exp 1/10/20/0", bus_valid, bus_access, bus_address, bus_strobe); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++; if (bus_valid !== 1'b1 || bus_address !== 8'h20 || arready !== 1'b0) begin fails++; $display("FAIL rd_stable%0d got v=%b a=%h exp 1/20", i, bus_valid, bus_address); end
    end
    bus_ready = 1; bus_read_data = 32'h12345678; bus_status = 2'b10;
    cyc();
    bus_ready = 0; bus_read_data = '0;
    tests++; if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rresp !== 2'b10) begin fails++; $display("FAIL rd_resp got v=%b d=%h r=%b exp 1/12345678/10", rvalid, rdata, rresp); end
    cyc();
    tests++; if (rvalid !== 1'b1 || rdata !== 32'h12345678) begin fails++; $display("FAIL rd_hold got v=%b d=%h exp 1/12345678", rvalid, rdata); end
    rready = 1;
    cyc();
    rready = 0;
    tests++; if (arready !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL rd_done got arr=%b v=%b exp 1/0", arready, rvalid); end
  endtask

  task automatic test_round_robin();
    bit last_wr;
    logic [1:0] first, second;
    logic [BW-1:0] rd;
    do_reset();
    last_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 1) begin
        arvalid = 1; araddr = AW'($urandom);
        cyc();
        arvalid = 0;
        tests++; if (bus_access !== 2'b10 || bus_valid !== 1'b1) begin fails++; $display("FAIL rr_solo%0d got acc=%b exp 10", k, bus_access); end
        last_wr = 1'b0;
        bus_ready = 1;
        cyc();
        bus_ready = 0; rready = 1;
        cyc();
        rready = 0;
      end
      awvalid = 1; wvalid = 1; arvalid = 1;
      awaddr = AW'($urandom); araddr = AW'($urandom); wdata = $urandom; wstrb = SW'($urandom);
      cyc();
      awvalid = 0; wvalid = 0; arvalid = 0;
      first  = last_wr ? 2'b10 : 2'b01;
      second = last_wr ? 2'b01 : 2'b10;
      tests++; if (bus_valid !== 1'b1 || bus_access !== first) begin fails++; $display("FAIL rr_first%0d got acc=%b exp %b", k, bus_access, first); end
      last_wr = (first == 2'b01);
      rd = $urandom;
      bus_ready = 1; bus_read_data = rd;
      cyc();
      bus_ready = 0;
      tests++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL rr_gap%0d got %b exp 0", k, bus_valid); end
      cyc();
      tests++; if (bus_valid !== 1'b1 || bus_access !== second) begin fails++; $display("FAIL rr_second%0d got acc=%b exp %b", k, bus_access, second); end
      last_wr = (second == 2'b01);
      bus_ready = 1;
      cyc();
      bus_ready = 0;
      tests++; if ({bvalid, rvalid} !== 2'b11 || rdata !== rd) begin fails++; $display("FAIL rr_resp%0d got bv=%b rv=%b d=%h exp 1/1/%h", k, bvalid, rvalid, rdata, rd); end
      bready = 1; rready = 1;
      cyc();
      bready = 0; rready = 0;
      tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL rr_free%0d got %b exp 111", k, {awready, wready, arready}); end
    end
  endtask

  task automatic test_bready_stall();
    logic [BW-1:0] rd;
    bit rd_done;
    awvalid = 1; wvalid = 1; awaddr = 8'h44; wdata = $urandom; wstrb = 4'hF;
    cyc();
    awvalid = 0; wvalid = 0;
    bus_ready = 1; bus_status = 2'b10;
    cyc();
    bus_ready = 0; bus_status = 2'b00;
    rd = $urandom;
    rd_done = 0;
    for (int c = 0; c < 10; c++) begin
      tests++; if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) begin fails++; $display("FAIL stall_b%0d got v=%b r=%b awr=%b exp 1/10/0", c, bvalid, bresp, awready); end
      if (rvalid) begin
        tests++; if (rdata !== rd) begin fails++; $display("FAIL stall_rdata got %h exp %h", rdata, rd); end
        rready = 1; rd_done = 1;
      end else rready = 0;
      if (bus_ready) bus_ready = 0;
      else if (bus_valid) begin bus_ready = 1; bus_read_data = rd; end
      arvalid = (c == 0); araddr = 8'h08;
      cyc();
    end
    rready = 0; arvalid = 0;
    tests++; if (rd_done !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL stall_read got done=%b rv=%b exp 1/0", rd_done, rvalid); end
    bready = 1;
    cyc();
    bready = 0;
    tests++; if ({awready, wready, bvalid} !== 3'b110) begin fails++; $display("FAIL stall_release got %b exp 110", {awready, wready, bvalid}); end
  endtask

  task automatic test_reset_midflight();
    arvalid = 1; araddr = 8'h30;
    cyc();
    arvalid = 0; bus_ready = 1; bus_read_data = 32'hA5A5A5A5;
    cyc();
    bus_ready = 0;
    awvalid = 1; wvalid = 1; awaddr = 8'h50; wdata = $urandom; wstrb = 4'h3;
    cyc();
    awvalid = 0; wvalid = 0;
    tests++; if (bus_valid !== 1'b1 || rvalid !== 1'b1) begin fails++; $display("FAIL rst_pre got bv=%b rv=%b exp 1/1", bus_valid, rvalid); end
    rst_n = 0;
    #1;
    tests++; if ({bus_valid, bvalid, rvalid} !== 3'b000) begin fails++; $display("FAIL rst_async got %b exp 000", {bus_valid, bvalid, rvalid}); end
    @(negedge clk);
    rst_n = 1;
    cyc();
    tests++; if ({awready, wready, arready} !== 3'b111 || bus_access !== 2'b00 || rdata !== '0) begin fails++; $display("FAIL rst_after got rdy=%b acc=%b d=%h exp 111/00/0", {awready, wready, arready}, bus_access, rdata); end
  endtask

  task automatic test_random();
    bit last_wr, do_w, do_r, tie, first_chk, busy, wr_srv, rd_srv, b_done, r_done, done;
    int wgap, lat, t;
    logic [AW-1:0] ea, ra;
    logic [BW-1:0] ed, exp_rdata;
    logic [SW-1:0] es;
    logic [1:0] exp_bresp, exp_rresp;
    last_wr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      do_w = 1'($urandom); do_r = 1'($urandom);
      if (!do_w && !do_r) do_w = 1;
      wgap = do_w ? $urandom_range(0, 2) : 0;
      ea = AW'($urandom); ra = AW'($urandom); ed = $urandom; es = SW'($urandom);
      tie = do_w && do_r && (wgap == 0);
      first_chk = 0; busy = 0; wr_srv = 0; rd_srv = 0; b_done = 0; r_done = 0; lat = 0;
      exp_bresp = 2'b00; exp_rresp = 2'b00; exp_rdata = '0;
      awaddr = ea; wdata = ed; wstrb = es; araddr = ra;
      done = 0; t = 0;
      while (!done && t < 60) begin
        if (bus_ready) bus_ready = 0;
        else if (bus_valid) begin
          if (!busy) begin
            busy = 1; lat = $urandom_range(0, 2);
            if (bus_access == 2'b01) begin
              tests++; if (!do_w || wr_srv || bus_address !== (ea & 8'hFC) || bus_write_data !== ed || bus_strobe !== es) begin fails++; $display("FAIL rand_wr%0d got a=%h d=%h s=%h exp %h/%h/%h", it, bus_address, bus_write_data, bus_strobe, ea & 8'hFC, ed, es); end
              wr_srv = 1;
            end else begin
              tests++; if (!do_r || rd_srv || bus_access !== 2'b10 || bus_address !== (ra & 8'hFC) || bus_strobe !== '0) begin fails++; $display("FAIL rand_rd%0d got acc=%b a=%h s=%h exp 10/%h/0", it, bus_access, bus_address, bus_strobe, ra & 8'hFC); end
              rd_srv = 1;
            end
            if (tie && !first_chk) begin
              tests++; if (bus_access !== (last_wr ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rand_tie%0d got %b exp %b", it, bus_access, last_wr ? 2'b10 : 2'b01); end
              first_chk = 1;
            end
            last_wr = (bus_access == 2'b01);
          end
          if (lat == 0) begin
            bus_ready = 1; bus_status = 2'($urandom); bus_read_data = $urandom; busy = 0;
            if (bus_access == 2'b01) exp_bresp = bus_status;
            else begin exp_rresp = bus_status; exp_rdata = bus_read_data; end
          end else lat--;
        end
        if (bready) bready = 0;
        else if (bvalid && $urandom_range(0, 1) == 1) begin
          tests++; if (!wr_srv || b_done || bresp !== exp_bresp) begin fails++; $display("FAIL rand_b%0d got %b exp %b", it, bresp, exp_bresp); end
          bready = 1; b_done = 1;
        end
        if (rready) rready = 0;
        else if (rvalid && $urandom_range(0, 1) == 1) begin
          tests++; if (!rd_srv || r_done || rresp !== exp_rresp || rdata !== exp_rdata) begin fails++; $display("FAIL rand_r%0d got %b/%h exp %b/%h", it, rresp, rdata, exp_rresp, exp_rdata); end
          rready = 1; r_done = 1;
        end
        wvalid  = do_w && (t == 0);
        awvalid = do_w && (t == wgap);
        arvalid = do_r && (t == 0);
        done = (!do_w || b_done) && (!do_r || r_done);
        cyc();
        t++;
      end
      bready = 0; rready = 0; bus_ready = 0; awvalid = 0; wvalid = 0; arvalid = 0;
      tests++; if (!done) begin fails++; $display("FAIL rand_timeout%0d got b=%b r=%b exp done", it, b_done, r_done); end
      tests++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin fails++; $display("FAIL rand_end%0d got %b exp 11100", it, {awready, wready, arready, bvalid, rvalid}); end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_read_status();
    test_round_robin();
    test_bready_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
